// File: rtl/max_three_pkg.sv
// Shared definitions for the max-of-three operand feeder: default widths,
// FSM state encoding and operand slot encoding.
package max_three_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_CNT_W  = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_EVAL    = 3'd2,
        ST_OUT     = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        SLOT_A = 2'd0,
        SLOT_B = 2'd1,
        SLOT_C = 2'd2
    } slot_t;

    // Slot C wraps back to A so the next triple starts cleanly.
    function automatic slot_t next_slot(input slot_t s);
        case (s)
            SLOT_A:  next_slot = SLOT_B;
            SLOT_B:  next_slot = SLOT_C;
            default: next_slot = SLOT_A;
        endcase
    endfunction

endpackage

// File: rtl/max_three_feeder.sv
// Operand sequencer for an external max-of-three core: packs stream words into
// (a, b, c) triples, registers the core result and streams it out per ap_start batch.
module max_three_feeder
    import max_three_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic              ap_start,
    output logic              ap_done,
    output logic              ap_idle,
    output logic              ap_ready,
    input  logic [CNT_W-1:0]  n_triples,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output logic [DATA_W-1:0] op_c,
    input  logic [DATA_W-1:0] core_ret,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready
);

    state_t           r_state;
    state_t           w_state_nxt;
    slot_t            r_slot;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_n;
    logic [CNT_W-1:0] w_count_inc;

    // Width-exact increment: n = 2^CNT_W-1 is reached by count = 2^CNT_W-2, never wrapping.
    assign w_count_inc = r_count + {{(CNT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_state  <= ST_IDLE;
            r_slot   <= SLOT_A;
            r_count  <= '0;
            r_n      <= '0;
            op_a     <= '0;
            op_b     <= '0;
            op_c     <= '0;
            out_data <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (ap_start) begin
                        r_n     <= n_triples;
                        r_count <= '0;
                        r_slot  <= SLOT_A;
                    end
                end
                ST_COLLECT: begin
                    if (in_valid) begin
                        case (r_slot)
                            SLOT_A:  op_a <= in_data;
                            SLOT_B:  op_b <= in_data;
                            default: op_c <= in_data;
                        endcase
                        r_slot <= next_slot(r_slot);
                    end
                end
                ST_EVAL: begin
                    out_data <= core_ret;
                end
                ST_OUT: begin
                    if (out_ready) begin
                        r_count <= w_count_inc;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (ap_start) begin
                    w_state_nxt = (n_triples == '0) ? ST_DONE : ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (in_valid && (r_slot == SLOT_C)) begin
                    w_state_nxt = ST_EVAL;
                end
            end
            ST_EVAL: begin
                w_state_nxt = ST_OUT;
            end
            ST_OUT: begin
                if (out_ready) begin
                    w_state_nxt = (w_count_inc == r_n) ? ST_DONE : ST_COLLECT;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Handshake and control outputs decode purely from the registered state.
    assign ap_idle   = (r_state == ST_IDLE);
    assign in_ready  = (r_state == ST_COLLECT);
    assign out_valid = (r_state == ST_OUT);
    assign ap_done   = (r_state == ST_DONE);
    assign ap_ready  = (r_state == ST_DONE);

endmodule
